// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter with internal line buffers and a 3-stage median network.
// Optional MEDIAN_FILTER_BYPASS_EN adds a bypass input that passes the window centre through.
module median_filter_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MEDIAN_FILTER_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          complete, win_sof, win_eol;

    pix_t lb0_q [IMG_W];
    pix_t lb1_q [IMG_W];
    // Window indexed [column][row]; column 2 is the newest, row 0 the top.
    pix_t win_q [3][3];

    logic v0_q, sof0_q, eol0_q;
    logic v1_q, sof1_q, eol1_q;
    logic v2_q, sof2_q, eol2_q;
    pix_t cmax_d [3];
    pix_t cmed_d [3];
    pix_t cmin_d [3];
    pix_t cmax_q [3];
    pix_t cmed_q [3];
    pix_t cmin_q [3];
    pix_t lo2_q, md2_q, hi2_q;
    pix_t out_data_d;
    logic out_valid_q, out_sof_q, out_eol_q;
    pix_t out_data_q;
`ifdef MEDIAN_FILTER_BYPASS_EN
    logic byp0_q, byp1_q, byp2_q;
    pix_t ctr1_q, ctr2_q;
`endif

    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
        complete = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        win_sof  = (cur_row == RW'(2)) && (cur_col == CW'(2));
        win_eol  = (cur_col == CW'(IMG_W - 1));
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb0_q[cur_col] <= in_data;
            win_q[0]       <= win_q[1];
            win_q[1]       <= win_q[2];
            win_q[2][0]    <= lb1_q[cur_col];
            win_q[2][1]    <= lb0_q[cur_col];
            win_q[2][2]    <= in_data;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cmax_d[i] = max2(max2(win_q[i][0], win_q[i][1]), win_q[i][2]);
            cmin_d[i] = min2(min2(win_q[i][0], win_q[i][1]), win_q[i][2]);
            cmed_d[i] = med3(win_q[i][0], win_q[i][1], win_q[i][2]);
        end
`ifdef MEDIAN_FILTER_BYPASS_EN
        out_data_d = byp2_q ? ctr2_q : med3(lo2_q, md2_q, hi2_q);
`else
        out_data_d = med3(lo2_q, md2_q, hi2_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            v0_q        <= 1'b0;
            sof0_q      <= 1'b0;
            eol0_q      <= 1'b0;
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            eol1_q      <= 1'b0;
            v2_q        <= 1'b0;
            sof2_q      <= 1'b0;
            eol2_q      <= 1'b0;
            cmax_q      <= '{default: '0};
            cmed_q      <= '{default: '0};
            cmin_q      <= '{default: '0};
            lo2_q       <= '0;
            md2_q       <= '0;
            hi2_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_data_q  <= '0;
`ifdef MEDIAN_FILTER_BYPASS_EN
            byp0_q      <= 1'b0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            ctr1_q      <= '0;
            ctr2_q      <= '0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            v0_q        <= complete;
            sof0_q      <= complete && win_sof;
            eol0_q      <= complete && win_eol;
            v1_q        <= v0_q;
            sof1_q      <= sof0_q;
            eol1_q      <= eol0_q;
            cmax_q      <= cmax_d;
            cmed_q      <= cmed_d;
            cmin_q      <= cmin_d;
            v2_q        <= v1_q;
            sof2_q      <= sof1_q;
            eol2_q      <= eol1_q;
            lo2_q       <= min2(min2(cmax_q[0], cmax_q[1]), cmax_q[2]);
            md2_q       <= med3(cmed_q[0], cmed_q[1], cmed_q[2]);
            hi2_q       <= max2(max2(cmin_q[0], cmin_q[1]), cmin_q[2]);
            out_valid_q <= v2_q;
            out_sof_q   <= sof2_q;
            out_eol_q   <= eol2_q;
            if (v2_q) begin
                out_data_q <= out_data_d;
            end
`ifdef MEDIAN_FILTER_BYPASS_EN
            byp0_q      <= in_valid && bypass;
            byp1_q      <= byp0_q;
            byp2_q      <= byp1_q;
            ctr1_q      <= win_q[1][1];
            ctr2_q      <= ctr1_q;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

endmodule
